// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared definitions for the SRAM controller and the surrounding pipeline:
//   - default data/address widths of the 32-bit pipeline and the 16-bit SRAM
//   - controller state encoding (2-bit constants plus a typed enum)
//   - pipeline opcode constants
//   - freeze helper used by the datapath stall logic
package sram_ctrl_pkg;

   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_SRAM_DW = 16;
   localparam int unsigned DEF_SRAM_AW = 18;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StLow  = ST_LOW,
      StHigh = ST_HIGH,
      StDone = ST_DONE
   } state_e;

   // Pipeline execute-stage opcodes
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_ORR = 4'd4;
   localparam logic [3:0] OP_EOR = 4'd5;
   localparam logic [3:0] OP_MOV = 4'd6;
   localparam logic [3:0] OP_LDR = 4'd8;
   localparam logic [3:0] OP_STR = 4'd9;
   localparam logic [3:0] OP_B   = 4'd10;

   // The whole pipeline stalls while memory is busy or a hazard is pending.
   function automatic logic pipe_freeze(input logic ready, input logic hazard);
      return ~ready | hazard;
   endfunction

endpackage

// File: rtl/sram_ctrl_wait_counter.sv
// sram_ctrl_wait_counter
//   4-bit wait-state counter. Counts up every cycle, returns to zero on clear
//   or reset, and flags the last cycle of a WAIT_CYCLES-long hold.
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   clear  reload the count with zero (asserted on every state change)
//   tc     terminal count: current cycle is the last of WAIT_CYCLES
module sram_ctrl_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tc
);

   localparam logic [3:0] TcVal = 4'(WAIT_CYCLES - 1);

   logic [3:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

   assign tc = (cnt_q == TcVal);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl
//   Bridges one 32-bit pipeline memory access onto a 16-bit asynchronous SRAM
//   as two half-word accesses (low half first), each held WAIT_CYCLES cycles.
//   ready drops while an access is in flight so the pipeline freezes.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   rd_en/wr_en  load/store request (store wins when both are set)
//   address      byte address; BASE_ADDR maps to SRAM word 0
//   write_data   store data
//   read_data    load data, valid in the ready cycle that ends a read
//   ready        0 = pipeline must freeze
//   sram_*       SRAM half-word address, write data, read data, write enable_n
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned SRAM_DW     = DEF_SRAM_DW,
   parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
   parameter int unsigned WAIT_CYCLES = 4,
   parameter int unsigned BASE_ADDR   = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [DATA_W-1:0]  write_data,
   output logic [DATA_W-1:0]  read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_wdata,
   input  logic [SRAM_DW-1:0] sram_rdata,
   output logic               sram_we_n
);

   state_e state_q, state_d;
   logic   is_write_q;
   logic   tc;
   logic   req;
   logic   in_access;
   logic   half;

   logic [DATA_W-1:0]  read_data_q;
   logic [SRAM_DW-1:0] rdata_lo_q;
   logic [31:0]        byte_off;
   logic               unused_addr_bits;

   assign req       = rd_en | wr_en;
   assign in_access = (state_q == StLow) || (state_q == StHigh);
   assign half      = (state_q == StHigh);

   sram_ctrl_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait_counter (
      .clk  (clk),
      .rst  (rst),
      .clear(state_d != state_q),
      .tc   (tc)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (req) state_d = StLow;
         StLow:   if (tc)  state_d = StHigh;
         StHigh:  if (tc)  state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         is_write_q  <= 1'b0;
         rdata_lo_q  <= '0;
         read_data_q <= '0;
      end else begin
         state_q <= state_d;
         // Request type is frozen for the whole access; a store wins over a load.
         if (state_q == StIdle && state_d == StLow) begin
            is_write_q <= wr_en;
         end
         // Low half is parked in a shadow so read_data only changes as a whole
         // word when the read completes.
         if (!is_write_q && state_q == StLow && tc) begin
            rdata_lo_q <= sram_rdata;
         end
         if (!is_write_q && state_q == StHigh && tc) begin
            read_data_q <= {sram_rdata, rdata_lo_q};
         end
      end
   end

   // Reset is synchronous, so the state register may still be mid-access while
   // rst is high; ready must already behave as in IDLE then.
   always_comb begin
      if (rst || state_q == StIdle) begin
         ready = ~req;
      end else begin
         ready = (state_q == StDone);
      end
   end

   // Bit SRAM_AW..2 of the byte offset is the word index truncated to
   // SRAM_AW-1 bits; low addresses wrap modulo the SRAM size.
   assign byte_off         = address - 32'(BASE_ADDR);
   assign unused_addr_bits = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

   assign sram_addr  = {byte_off[SRAM_AW:2], half};
   assign sram_wdata = half ? write_data[DATA_W-1:SRAM_DW] : write_data[SRAM_DW-1:0];
   assign sram_we_n  = ~(is_write_q & in_access);
   assign read_data  = read_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
//   Self-checking bench: two controllers (WAIT_CYCLES=4 and 1) on behavioural
//   SRAM models. Expected load data comes from a reference memory the bench
//   fills as it issues stores; expected results go through a scoreboard queue.
module tb_sram_ctrl;

   logic clk;
   logic rst;

   // Default-configuration controller
   logic        rd_en, wr_en;
   logic [31:0] address, write_data, read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_wdata, sram_rdata;
   logic        sram_we_n;

   // WAIT_CYCLES=1 controller
   logic        rd_en1, wr_en1;
   logic [31:0] address1, write_data1, read_data1;
   logic        ready1;
   logic [17:0] sram_addr1;
   logic [15:0] sram_wdata1, sram_rdata1;
   logic        sram_we_n1;

   logic [15:0] mem0 [0:255];
   logic [15:0] mem1 [0:15];
   logic [15:0] ref_mem [logic [17:0]];
   logic [31:0] sb [$];
   logic [31:0] last_rd;

   int n_checks;
   int n_fail;

   sram_ctrl u_dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .wr_en     (wr_en),
      .address   (address),
      .write_data(write_data),
      .read_data (read_data),
      .ready     (ready),
      .sram_addr (sram_addr),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata),
      .sram_we_n (sram_we_n)
   );

   sram_ctrl #(
      .WAIT_CYCLES(1)
   ) u_dut_fast (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en1),
      .wr_en     (wr_en1),
      .address   (address1),
      .write_data(write_data1),
      .read_data (read_data1),
      .ready     (ready1),
      .sram_addr (sram_addr1),
      .sram_wdata(sram_wdata1),
      .sram_rdata(sram_rdata1),
      .sram_we_n (sram_we_n1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM models: asynchronous read, write while we_n is low.
   always @(posedge clk) if (!sram_we_n) mem0[sram_addr[7:0]] <= sram_wdata;
   assign sram_rdata  = mem0[sram_addr[7:0]];
   assign sram_rdata1 = mem1[sram_addr1[3:0]];

   initial begin
      mem1[0] = 16'h1111;
      mem1[1] = 16'h2222;
      mem1[2] = 16'h3333;
      mem1[3] = 16'h4444;
      for (int i = 4; i < 16; i++) mem1[i] = 16'h0000;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input bit trace);
      logic [31:0] off;
      logic [17:0] a_lo, a_hi;
      logic [31:0] exp;
      bit          seen;
      off  = addr - 32'd1024;
      a_lo = {off[18:2], 1'b0};
      a_hi = {off[18:2], 1'b1};
      if (wr) begin
         ref_mem[a_lo] = data[15:0];
         ref_mem[a_hi] = data[31:16];
         sb.push_back(last_rd);
      end else begin
         exp = {ref_mem[a_hi], ref_mem[a_lo]};
         sb.push_back(exp);
         last_rd = exp;
      end
      @(posedge clk); #1;
      rd_en = rd; wr_en = wr; address = addr; write_data = data;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (trace && wr && k >= 1 && k <= 8) begin
            check_eq("wr_addr", 32'(sram_addr), 32'((k <= 4) ? a_lo : a_hi));
            check_eq("wr_data", 32'(sram_wdata), 32'((k <= 4) ? data[15:0] : data[31:16]));
            check_eq("wr_we_n", 32'(sram_we_n), 32'd0);
         end
         if (k == 0) begin
            check_eq("req_ready", 32'(ready), 32'd0);
            check_eq("req_we_n", 32'(sram_we_n), 32'd1);
         end else if (ready) begin
            seen = 1;
            check_eq("latency", 32'(k), 32'd9);
            check_eq("read_data", read_data, sb.pop_front());
         end
      end
      if (!seen) check_eq("timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      rd_en = 0; wr_en = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_fail = 0; last_rd = 32'h0;
      rst = 1; rd_en = 0; wr_en = 0; address = 32'd1024; write_data = 32'h0;
      rd_en1 = 0; wr_en1 = 0; address1 = 32'd1024; write_data1 = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", 32'(ready), 32'd1);
      check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
      check_eq("rst_rdata", read_data, 32'h0);
      @(posedge clk); #1;
      rst = 0;

      // Idle: ready and we_n stay high
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("idle_ready", 32'(ready), 32'd1);
         check_eq("idle_we_n", 32'(sram_we_n), 32'd1);
      end

      do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1);
      do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check_eq("rd_hold", read_data, last_rd);
      end

      // Both requests: store only, load data untouched
      do_access(1'b1, 1'b1, 32'd2000, 32'h12345678, 1'b1);
      check_eq("both_hold", read_data, 32'hDEADBEEF);
      do_access(1'b1, 1'b0, 32'd2000, 32'h0, 1'b0);

      // Address below the base wraps to the top of SRAM
      do_access(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 1'b1);
      do_access(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);

      // Reset in cycle 5 of a store
      @(posedge clk); #1;
      wr_en = 1; address = 32'd1032; write_data = 32'hAAAA5555;
      repeat (4) @(negedge clk);
      @(negedge clk);
      check_eq("mid_we_n_c4", 32'(sram_we_n), 32'd0);
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      check_eq("mid_rst_ready_req", 32'(ready), 32'd0);
      @(posedge clk); #1;
      wr_en = 0;
      @(negedge clk);
      check_eq("mid_rst_we_n", 32'(sram_we_n), 32'd1);
      check_eq("mid_rst_ready", 32'(ready), 32'd1);
      check_eq("mid_rst_rdata", read_data, 32'h0);
      @(posedge clk); #1;
      rst = 0;
      last_rd = 32'h0;
      @(negedge clk);
      check_eq("post_rst_ready", 32'(ready), 32'd1);
      check_eq("post_rst_we_n", 32'(sram_we_n), 32'd1);
      do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);

      // WAIT_CYCLES=1: back-to-back loads, ready at cycles 3 and 7
      sb.push_back(32'h22221111);
      sb.push_back(32'h44443333);
      @(posedge clk); #1;
      rd_en1 = 1; address1 = 32'd1024;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_eq("b2b_ready", 32'(ready1), 32'((k == 3) || (k == 7)));
         check_eq("b2b_we_n", 32'(sram_we_n1), 32'd1);
         if (ready1) check_eq("b2b_data", read_data1, sb.pop_front());
         if (k == 3) begin
            @(posedge clk); #1;
            address1 = 32'd1028;
         end
      end
      @(posedge clk); #1;
      rd_en1 = 0;
      check_eq("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
